tcm_arbiter: RTL and testbench
==============================

Name: tcm_arbiter

Overview:
Two-requester arbiter in front of tcm_controller. It shares the single-port TCM between the instruction-fetch port (p0) and the data port (p1). Arbitration is round-robin, with a one-entry holding buffer per port so that a losing request is replayed on the next cycle. The upstream protocol keeps TCM timing: one request per cycle per port, with the response or fault exactly one cycle after the request is issued to the TCM.

Parameters:
AW, `TCM_VA_WIDTH, TCM byte-address width.
DW, `BUS_WIDTH, data width (32).
ACCW, `BUS_ACC_WIDTH, access-size code width.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
pN_req  in  1  request pulse; one cycle per transaction; N = 0, 1
pN_addr  in  AW  byte address
pN_w_rb  in  1  1 = write, 0 = read
pN_acc  in  ACCW  access size (`BUS_ACC_1B/2B/4B)
pN_wdata  in  DW  write data
pN_stall  out  1  1 = holding buffer occupied; requester must not pulse req
pN_resp  out  1  transaction completed (rdata valid for reads)
pN_fault  out  1  transaction rejected by TCM
pN_rdata  out  DW  read data; valid only with pN_resp
tcm_req  out  1  to tcm_controller req
tcm_addr  out  AW  to tcm_controller addr
tcm_w_rb  out  1  to tcm_controller w_rb
tcm_acc  out  ACCW  to tcm_controller acc
tcm_wdata  out  DW  to tcm_controller wdata
tcm_rdata  in  DW  from tcm_controller rdata
tcm_resp  in  1  from tcm_controller resp (one cycle after req)
tcm_fault  in  1  from tcm_controller fault (combinational, same cycle as req)

Behaviour:
- Reset: async on rstn low. Outputs and state after reset:
  - buf_vld0/1 = 0, so pN_stall = 0.
  - issued_q = 0, owner_q = 0, fault_q = 0.
  - rr_last = 1, so p0 wins the first tie.
  - pN_resp = 0, pN_fault = 0, tcm_req = 0.
- Candidate per port N:
  - If buf_vldN, the buffered request.
  - Else if pN_req, the live inputs.
  - Else none.
  - A pN_req pulsed while pN_stall = 1 is ignored: not buffered, no resp, no fault.
- Grant, combinational:
  - One candidate: grant it.
  - Both candidates: grant the port != rr_last.
  - None: tcm_req = 0.
  - When a grant occurs, rr_last <= granted index.
- Downstream: tcm_req = any candidate. tcm_addr/w_rb/acc/wdata are muxed from the granted candidate. With no grant they hold the p0 path values, which are don't-care.
- Loser handling: a live (non-buffered) losing candidate is captured into bufN at the clock edge, and buf_vldN <= 1. A buffered candidate that loses stays buffered.
- Buffer release: buf_vldN <= 0 at the edge where the buffered entry is granted.
- Starvation bound: round-robin guarantees a buffered request is granted on the next cycle. Worst-case added latency is 1 cycle.
- Issue tracking, registered every edge:
  - issued_q <= tcm_req.
  - owner_q <= granted index.
  - fault_q <= tcm_req & tcm_fault.
- Responses:
  - pN_resp = issued_q & (owner_q == N) & tcm_resp.
  - pN_fault = issued_q & (owner_q == N) & fault_q.
  - pN_rdata = tcm_rdata, broadcast to both ports and qualified by pN_resp.
  - Exactly one of resp/fault fires per issued transaction, one cycle after issue.
- Throughput: one TCM access per cycle sustained. A port that loses sees stall = 1 for exactly one cycle.
- Reset mid-operation: buffered and in-flight transactions are dropped silently. No resp or fault is produced for them after rstn deasserts.
- Writes are not merged or reordered. TCM order equals grant order, and per-port order is preserved.

Test Plan:
- Single read: p0_req with addr = 0x10, acc = 4B, p1 idle -> tcm_req the same cycle; p0_resp the next cycle with p0_rdata = stored word; p0_stall stays 0.
- Simultaneous after reset: p0 and p1 pulse req on the same cycle -> p0 issued at cycle T and p1 at T+1. p1_stall = 1 during T+1 only. p0_resp at T+1, p1_resp at T+2.
- Continuous contention: both ports request every cycle they are not stalled, for 8 cycles -> grants alternate 0, 1, 0, 1; every cycle has tcm_req = 1; no request is lost; per-port responses arrive in order.
- Fault routing: p1 sends a 4B write to addr = 0x2 while p0 reads 0x0 on the same cycle -> p0_resp at T+1; p1 issued at T+1; p1_fault at T+2; p1_resp never asserts; the TCM word is unchanged.
- Stall violation: p1 pulses req again while p1_stall = 1 -> the second request is ignored; exactly one p1_resp is seen.
- Reset mid-flight: rstn low in the cycle after a contention (p1 buffered) -> no resp or fault after release; stall = 0; the first tie after release goes to p0.

Source files
------------

// File: rtl/tcm_arbiter.sv
// Round-robin arbiter sharing one single-port TCM between a fetch port (p0) and a data port (p1).
// Grant is combinational; resp/fault return one cycle after issue; a losing port is held for one cycle (stall).
module tcm_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int ACCW = 2
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            p0_req,
  input  logic [AW-1:0]   p0_addr,
  input  logic            p0_w_rb,
  input  logic [ACCW-1:0] p0_acc,
  input  logic [DW-1:0]   p0_wdata,
  output logic            p0_stall,
  output logic            p0_resp,
  output logic            p0_fault,
  output logic [DW-1:0]   p0_rdata,

  input  logic            p1_req,
  input  logic [AW-1:0]   p1_addr,
  input  logic            p1_w_rb,
  input  logic [ACCW-1:0] p1_acc,
  input  logic [DW-1:0]   p1_wdata,
  output logic            p1_stall,
  output logic            p1_resp,
  output logic            p1_fault,
  output logic [DW-1:0]   p1_rdata,

  output logic            tcm_req,
  output logic [AW-1:0]   tcm_addr,
  output logic            tcm_w_rb,
  output logic [ACCW-1:0] tcm_acc,
  output logic [DW-1:0]   tcm_wdata,
  input  logic [DW-1:0]   tcm_rdata,
  input  logic            tcm_resp,
  input  logic            tcm_fault
);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            w_rb;
    logic [ACCW-1:0] acc;
    logic [DW-1:0]   wdata;
  } req_t;

  req_t live0, live1;
  req_t cand0, cand1, gnt_req;
  req_t buf0_q, buf0_d, buf1_q, buf1_d;
  logic buf_vld0_q, buf_vld0_d, buf_vld1_q, buf_vld1_d;
  logic rr_last_q, rr_last_d;
  logic issued_q, owner_q, fault_q;
  logic cand_vld0, cand_vld1, gnt_idx;

  // A buffered entry always takes precedence over the live inputs, which is
  // also what makes a req pulsed during stall disappear.
  always_comb begin
    live0     = {p0_addr, p0_w_rb, p0_acc, p0_wdata};
    live1     = {p1_addr, p1_w_rb, p1_acc, p1_wdata};
    cand_vld0 = buf_vld0_q | p0_req;
    cand_vld1 = buf_vld1_q | p1_req;
    cand0     = buf_vld0_q ? buf0_q : live0;
    cand1     = buf_vld1_q ? buf1_q : live1;

    if (cand_vld0 && cand_vld1) begin
      gnt_idx = ~rr_last_q;
    end else begin
      gnt_idx = cand_vld1 & ~cand_vld0;
    end
    gnt_req = gnt_idx ? cand1 : cand0;
  end

  assign tcm_req   = cand_vld0 | cand_vld1;
  assign tcm_addr  = gnt_req.addr;
  assign tcm_w_rb  = gnt_req.w_rb;
  assign tcm_acc   = gnt_req.acc;
  assign tcm_wdata = gnt_req.wdata;

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    buf_vld0_d = buf_vld0_q;
    buf_vld1_d = buf_vld1_q;
    rr_last_d  = rr_last_q;

    if (tcm_req) begin
      rr_last_d = gnt_idx;
      if (!gnt_idx) begin
        buf_vld0_d = 1'b0;
        if (cand_vld1 && !buf_vld1_q) begin
          buf_vld1_d = 1'b1;
          buf1_d     = live1;
        end
      end else begin
        buf_vld1_d = 1'b0;
        if (cand_vld0 && !buf_vld0_q) begin
          buf_vld0_d = 1'b1;
          buf0_d     = live0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      buf_vld0_q <= 1'b0;
      buf_vld1_q <= 1'b0;
      rr_last_q  <= 1'b1;
      issued_q   <= 1'b0;
      owner_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      buf_vld0_q <= buf_vld0_d;
      buf_vld1_q <= buf_vld1_d;
      rr_last_q  <= rr_last_d;
      issued_q   <= tcm_req;
      owner_q    <= gnt_idx;
      fault_q    <= tcm_req & tcm_fault;
    end
  end

  // Controller fault is combinational, so it is registered to line up with resp.
  assign p0_stall = buf_vld0_q;
  assign p1_stall = buf_vld1_q;
  assign p0_resp  = issued_q & ~owner_q & tcm_resp;
  assign p1_resp  = issued_q &  owner_q & tcm_resp;
  assign p0_fault = issued_q & ~owner_q & fault_q;
  assign p1_fault = issued_q &  owner_q & fault_q;
  assign p0_rdata = tcm_rdata;
  assign p1_rdata = tcm_rdata;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: a TCM stand-in, a transaction-level model checked every negedge, and directed scenarios.
module tb_tcm_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int ACCW = 2;
  localparam logic [ACCW-1:0] ACC1 = 2'd0;
  localparam logic [ACCW-1:0] ACC2 = 2'd1;
  localparam logic [ACCW-1:0] ACC4 = 2'd2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            p0_req = 1'b0, p1_req = 1'b0;
  logic [AW-1:0]   p0_addr = '0, p1_addr = '0;
  logic            p0_w_rb = 1'b0, p1_w_rb = 1'b0;
  logic [ACCW-1:0] p0_acc = '0, p1_acc = '0;
  logic [DW-1:0]   p0_wdata = '0, p1_wdata = '0;
  logic            p0_stall, p1_stall, p0_resp, p1_resp, p0_fault, p1_fault;
  logic [DW-1:0]   p0_rdata, p1_rdata;
  logic            tcm_req, tcm_w_rb;
  logic [AW-1:0]   tcm_addr;
  logic [ACCW-1:0] tcm_acc;
  logic [DW-1:0]   tcm_wdata;
  logic [DW-1:0]   tcm_rdata = '0;
  logic            tcm_resp = 1'b0;
  logic            tcm_fault;

  tcm_arbiter #(.AW(AW), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_w_rb(p0_w_rb), .p0_acc(p0_acc), .p0_wdata(p0_wdata),
    .p0_stall(p0_stall), .p0_resp(p0_resp), .p0_fault(p0_fault), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_w_rb(p1_w_rb), .p1_acc(p1_acc), .p1_wdata(p1_wdata),
    .p1_stall(p1_stall), .p1_resp(p1_resp), .p1_fault(p1_fault), .p1_rdata(p1_rdata),
    .tcm_req(tcm_req), .tcm_addr(tcm_addr), .tcm_w_rb(tcm_w_rb), .tcm_acc(tcm_acc),
    .tcm_wdata(tcm_wdata), .tcm_rdata(tcm_rdata), .tcm_resp(tcm_resp), .tcm_fault(tcm_fault)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            w;
    logic [ACCW-1:0] acc;
    logic [DW-1:0]   wdata;
  } txn_t;

  function automatic bit misaligned(input logic [AW-1:0] a, input logic [ACCW-1:0] acc);
    return (acc == ACC4 && a[1:0] != 2'd0) || (acc == ACC2 && a[0]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [AW-1:0] a,
                                        input logic [ACCW-1:0] acc, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (acc)
      ACC1:    r[int'(a[1:0])*8 +: 8] = wd[7:0];
      ACC2:    r[int'(a[1])*16 +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // TCM stand-in: fault is same-cycle, resp and read data one cycle later.
  logic [31:0] smem [0:63];
  assign tcm_fault = tcm_req && misaligned(tcm_addr, tcm_acc);
  always @(posedge clk) begin
    tcm_resp <= tcm_req && !tcm_fault;
    if (tcm_req && !tcm_fault) begin
      if (!tcm_w_rb) tcm_rdata <= smem[tcm_addr[7:2]];
      else smem[tcm_addr[7:2]] <= merge(smem[tcm_addr[7:2]], tcm_addr, tcm_acc, tcm_wdata);
    end
  end

  // Transaction model: per-port waiting slot, last-served port, one in-flight result.
  logic [31:0] mmem [0:63];
  bit          pend_v [2];
  txn_t        pend [2];
  int          last_srv = 1;
  bit          if_v = 0, if_fault = 0;
  int          if_port = 0;
  logic [31:0] if_rdata = '0;

  function automatic txn_t live_txn(input int n);
    if (n == 0) return {p0_addr, p0_w_rb, p0_acc, p0_wdata};
    return {p1_addr, p1_w_rb, p1_acc, p1_wdata};
  endfunction

  function automatic int winner(input bit h0, input bit h1);
    if (h0 && h1) return (last_srv == 0) ? 1 : 0;
    return (h1 && !h0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rstn) begin : model
    bit   h [2];
    txn_t t [2];
    int   w;
    if (!rstn) begin
      pend_v[0] = 0; pend_v[1] = 0; if_v = 0; last_srv = 1;
    end else begin
      h[0] = pend_v[0] || p0_req;
      h[1] = pend_v[1] || p1_req;
      for (int n = 0; n < 2; n++) t[n] = pend_v[n] ? pend[n] : live_txn(n);
      if_v = h[0] || h[1];
      if (if_v) begin
        w        = winner(h[0], h[1]);
        if_port  = w;
        if_fault = misaligned(t[w].addr, t[w].acc);
        if_rdata = mmem[t[w].addr[7:2]];
        if (t[w].w && !if_fault)
          mmem[t[w].addr[7:2]] = merge(mmem[t[w].addr[7:2]], t[w].addr, t[w].acc, t[w].wdata);
        last_srv  = w;
        pend_v[w] = 0;
        if (h[1-w] && !pend_v[1-w]) begin
          pend_v[1-w] = 1;
          pend[1-w]   = t[1-w];
        end
      end
    end
  end

  bit chk_en = 0;
  int n_resp0 = 0, n_resp1 = 0, n_flt0 = 0, n_flt1 = 0;

  always @(negedge clk) begin : compare
    bit   h0, h1, er0, er1;
    txn_t t [2];
    int   w;
    if (chk_en) begin
      h0 = pend_v[0] || p0_req;
      h1 = pend_v[1] || p1_req;
      t[0] = pend_v[0] ? pend[0] : live_txn(0);
      t[1] = pend_v[1] ? pend[1] : live_txn(1);
      w = winner(h0, h1);
      chk("p0_stall", p0_stall, pend_v[0]);
      chk("p1_stall", p1_stall, pend_v[1]);
      chk("tcm_req", tcm_req, h0 || h1);
      if (h0 || h1) begin
        chk("tcm_addr", tcm_addr, t[w].addr);
        chk("tcm_w_rb", tcm_w_rb, t[w].w);
        chk("tcm_acc", tcm_acc, t[w].acc);
        chk("tcm_wdata", tcm_wdata, t[w].wdata);
      end
      er0 = if_v && if_port == 0 && !if_fault;
      er1 = if_v && if_port == 1 && !if_fault;
      chk("p0_resp", p0_resp, er0);
      chk("p1_resp", p1_resp, er1);
      chk("p0_fault", p0_fault, if_v && if_port == 0 && if_fault);
      chk("p1_fault", p1_fault, if_v && if_port == 1 && if_fault);
      if (er0) chk("p0_rdata", p0_rdata, if_rdata);
      if (er1) chk("p1_rdata", p1_rdata, if_rdata);
      if (p0_resp === 1'b1) n_resp0++;
      if (p1_resp === 1'b1) n_resp1++;
      if (p0_fault === 1'b1) n_flt0++;
      if (p1_fault === 1'b1) n_flt1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0;
    p1_req = 0;
  endtask

  task automatic drv0(input logic [AW-1:0] a, input logic w, input logic [ACCW-1:0] acc, input logic [31:0] wd);
    p0_req = 1; p0_addr = a; p0_w_rb = w; p0_acc = acc; p0_wdata = wd;
  endtask

  task automatic drv1(input logic [AW-1:0] a, input logic w, input logic [ACCW-1:0] acc, input logic [31:0] wd);
    p1_req = 1; p1_addr = a; p1_w_rb = w; p1_acc = acc; p1_wdata = wd;
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    tick();
    rstn = 1;
    tick();
  endtask

  initial begin
    int r0, r1, f0, f1, busy;
    logic [AW-1:0] a0, a1;
    for (int i = 0; i < 64; i++) begin
      smem[i] = 32'hA000_0000 | i;
      mmem[i] = 32'hA000_0000 | i;
    end
    rstn = 1;
    #1 rstn = 0;
    tick();
    chk_en = 1;
    #3;
    chk("reset_p0_stall", p0_stall, 0);
    chk("reset_p1_stall", p1_stall, 0);
    chk("reset_tcm_req", tcm_req, 0);
    chk("reset_p0_resp", p0_resp, 0);
    chk("reset_p1_fault", p1_fault, 0);
    tick();
    rstn = 1;
    tick();

    // Single read
    drv0(16'h10, 0, ACC4, 0);
    #3;
    chk("single_tcm_req", tcm_req, 1);
    chk("single_tcm_addr", tcm_addr, 16'h10);
    tick();
    idle();
    #3;
    chk("single_p0_resp", p0_resp, 1);
    chk("single_p0_rdata", p0_rdata, 32'hA000_0004);
    chk("single_p0_stall", p0_stall, 0);
    tick();

    // Simultaneous requests right after reset: p0 first
    do_reset();
    drv0(16'h20, 0, ACC4, 0);
    drv1(16'h24, 0, ACC4, 0);
    #3;
    chk("sim_first_addr", tcm_addr, 16'h20);
    chk("sim_p1_stall_T", p1_stall, 0);
    tick();
    idle();
    #3;
    chk("sim_p1_stall_T1", p1_stall, 1);
    chk("sim_second_addr", tcm_addr, 16'h24);
    chk("sim_p0_resp", p0_resp, 1);
    chk("sim_p0_rdata", p0_rdata, 32'hA000_0008);
    tick();
    #3;
    chk("sim_p1_resp", p1_resp, 1);
    chk("sim_p1_rdata", p1_rdata, 32'hA000_0009);
    chk("sim_p1_stall_T2", p1_stall, 0);
    tick();

    // Continuous contention for 8 cycles
    r0 = n_resp0; r1 = n_resp1; busy = 0;
    a0 = 16'h00; a1 = 16'h40;
    for (int c = 0; c < 8; c++) begin
      p0_req = !pend_v[0];
      p1_req = !pend_v[1];
      if (p0_req) begin drv0(a0, 0, ACC4, 0); a0 = a0 + 16'd4; end
      if (p1_req) begin drv1(a1, 0, ACC4, 0); a1 = a1 + 16'd4; end
      #3;
      if (tcm_req === 1'b1) busy++;
      tick();
    end
    idle();
    tick(); tick(); tick();
    chk("cont_busy_cycles", busy, 8);
    chk("cont_p0_resps", n_resp0 - r0, 5);
    chk("cont_p1_resps", n_resp1 - r1, 4);

    // Fault routing: misaligned 4B write from p1
    do_reset();
    r1 = n_resp1; f1 = n_flt1;
    drv0(16'h0, 0, ACC4, 0);
    drv1(16'h2, 1, ACC4, 32'hDEAD_BEEF);
    #3;
    chk("flt_first_addr", tcm_addr, 16'h0);
    tick();
    idle();
    #3;
    chk("flt_p0_resp", p0_resp, 1);
    chk("flt_p1_issue_addr", tcm_addr, 16'h2);
    tick();
    #3;
    chk("flt_p1_fault", p1_fault, 1);
    chk("flt_p1_resp", p1_resp, 0);
    tick();
    drv0(16'h0, 0, ACC4, 0);
    tick();
    idle();
    #3;
    chk("flt_word_unchanged", p0_rdata, 32'hA000_0000);
    tick(); tick();
    chk("flt_p1_resp_count", n_resp1 - r1, 0);
    chk("flt_p1_fault_count", n_flt1 - f1, 1);

    // Stall violation: second p1 req during stall is dropped
    do_reset();
    r0 = n_resp0; r1 = n_resp1;
    drv0(16'h30, 0, ACC4, 0);
    drv1(16'h34, 0, ACC4, 0);
    tick();
    p0_req = 0;
    drv1(16'h38, 0, ACC4, 0);
    #3;
    chk("stallv_addr", tcm_addr, 16'h34);
    chk("stallv_p1_stall", p1_stall, 1);
    tick();
    idle();
    tick(); tick(); tick();
    chk("stallv_p1_count", n_resp1 - r1, 1);
    chk("stallv_p0_count", n_resp0 - r0, 1);

    // Reset while p1 is buffered and p0 in flight
    drv0(16'h10, 0, ACC4, 0);
    drv1(16'h14, 0, ACC4, 0);
    tick();
    idle();
    r0 = n_resp0; r1 = n_resp1; f0 = n_flt0; f1 = n_flt1;
    #1 rstn = 0;
    #2;
    chk("rst_p1_stall", p1_stall, 0);
    chk("rst_p0_resp", p0_resp, 0);
    tick();
    rstn = 1;
    tick(); tick();
    chk("rst_no_resp", (n_resp0 - r0) + (n_resp1 - r1), 0);
    chk("rst_no_fault", (n_flt0 - f0) + (n_flt1 - f1), 0);
    drv0(16'h18, 0, ACC4, 0);
    drv1(16'h1C, 0, ACC4, 0);
    #3;
    chk("rst_tie_p0", tcm_addr, 16'h18);
    tick();
    idle();
    tick(); tick();
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
